phaser_in_tap_ctrl: RTL and testbench



---
 rtl/phaser_in_tap_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_phaser_in_tap_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/phaser_in_tap_ctrl.sv
// Request sequencer driving the PHASER_IN fine-delay and coarse-counter pins.
// Optional build macro PHASER_IN_TAP_CTRL_OVF_ABORT_EN: FINEOVERFLOW during SETTLE aborts a fine op.
module phaser_in_tap_ctrl #(
    parameter int FINE_MAX      = 63,
    parameter int SETTLE_CYCLES = 8,
    parameter int READ_LAT      = 2
) (
    input  logic       SYSCLK,
    input  logic       RST_N,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [1:0] REQ_OP,
    input  logic [5:0] REQ_DATA,
    output logic       RSP_VALID,
    input  logic       RSP_READY,
    output logic [5:0] RSP_DATA,
    output logic       RSP_ERR,
    output logic [5:0] FINE_TAP,
    output logic       FINEENABLE,
    output logic       FINEINC,
    output logic       COUNTERLOADEN,
    output logic [5:0] COUNTERLOADVAL,
    output logic       COUNTERREADEN,
    input  logic       FINEOVERFLOW,
    input  logic [5:0] COUNTERREADVAL,
    output logic [2:0] DBG_STATE,
    output logic       DBG_OVF
);

    // Handshakes: a request transfers on an edge where REQ_VALID && REQ_READY;
    // a response transfers on an edge where RSP_VALID && RSP_READY. Both valids
    // hold their payload stable until the transfer.

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_STEP   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_LOAD   = 3'd3;
    localparam logic [2:0] S_RDWAIT = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    localparam logic [1:0] OP_SET   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_ZERO  = 2'b11;

    localparam logic [5:0] FINE_MAX_V  = 6'(FINE_MAX);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] READ_LAST   = 8'(READ_LAT);

    logic [2:0] state_q, state_d;
    logic [5:0] tap_q, tap_d;
    logic [5:0] target_q, target_d;
    logic       is_load_q, is_load_d;
    logic [7:0] cnt_q, cnt_d;
    logic [5:0] rsp_data_q, rsp_data_d;
    logic       rsp_err_q, rsp_err_d;
    logic [5:0] loadval_q, loadval_d;
    logic       ovf_q, ovf_d;

    logic [5:0] req_target;
    logic       abort;

    assign req_target = (REQ_OP == OP_ZERO) ? 6'd0 : REQ_DATA;

    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        target_d   = target_q;
        is_load_d  = is_load_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        loadval_d  = loadval_q;
        ovf_d      = ovf_q;
        abort      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (REQ_VALID) begin
                    cnt_d = 8'd0;
                    case (REQ_OP)
                        OP_SET, OP_ZERO: begin
                            target_d  = req_target;
                            is_load_d = 1'b0;
                            ovf_d     = 1'b0;
                            if (req_target > FINE_MAX_V) begin
                                rsp_data_d = tap_q;
                                rsp_err_d  = 1'b1;
                                state_d    = S_RESP;
                            end else if (req_target == tap_q) begin
                                rsp_data_d = tap_q;
                                rsp_err_d  = 1'b0;
                                state_d    = S_RESP;
                            end else begin
                                state_d = S_STEP;
                            end
                        end
                        OP_LOAD: begin
                            loadval_d = REQ_DATA;
                            is_load_d = 1'b1;
                            state_d   = S_LOAD;
                        end
                        default: begin
                            state_d = S_RDWAIT;
                        end
                    endcase
                end
            end

            S_STEP: begin
                if (target_q > tap_q) begin
                    if (tap_q < FINE_MAX_V) tap_d = tap_q + 6'd1;
                end else if (tap_q != 6'd0) begin
                    tap_d = tap_q - 6'd1;
                end
                cnt_d   = 8'd0;
                state_d = S_SETTLE;
            end

            S_SETTLE: begin
                if (!is_load_q) ovf_d = ovf_q | FINEOVERFLOW;
`ifdef PHASER_IN_TAP_CTRL_OVF_ABORT_EN
                abort = !is_load_q && (ovf_q || FINEOVERFLOW);
`endif
                if (cnt_q == SETTLE_LAST) begin
                    if (is_load_q) begin
                        rsp_data_d = loadval_q;
                        rsp_err_d  = 1'b0;
                        state_d    = S_RESP;
                    end else if (abort) begin
                        rsp_data_d = tap_q;
                        rsp_err_d  = 1'b1;
                        state_d    = S_RESP;
                    end else if (tap_q != target_q) begin
                        state_d = S_STEP;
                    end else begin
                        rsp_data_d = tap_q;
                        rsp_err_d  = 1'b0;
                        state_d    = S_RESP;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_LOAD: begin
                cnt_d   = 8'd0;
                state_d = S_SETTLE;
            end

            // cnt_q == 0 is the COUNTERREADEN cycle; the value is valid READ_LAT cycles later.
            S_RDWAIT: begin
                if (cnt_q == READ_LAST) begin
                    rsp_data_d = COUNTERREADVAL;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_RESP: begin
                if (RSP_READY) state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge SYSCLK) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            tap_q      <= 6'd0;
            target_q   <= 6'd0;
            is_load_q  <= 1'b0;
            cnt_q      <= 8'd0;
            rsp_data_q <= 6'd0;
            rsp_err_q  <= 1'b0;
            loadval_q  <= 6'd0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tap_q      <= tap_d;
            target_q   <= target_d;
            is_load_q  <= is_load_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            loadval_q  <= loadval_d;
            ovf_q      <= ovf_d;
        end
    end

    // Pulses decode straight from registered state, so reset cuts them at the same edge.
    assign REQ_READY      = (state_q == S_IDLE);
    assign RSP_VALID      = (state_q == S_RESP);
    assign RSP_DATA       = rsp_data_q;
    assign RSP_ERR        = rsp_err_q;
    assign FINE_TAP       = tap_q;
    assign FINEENABLE     = (state_q == S_STEP);
    assign FINEINC        = (state_q == S_STEP) && (target_q > tap_q);
    assign COUNTERLOADEN  = (state_q == S_LOAD);
    assign COUNTERLOADVAL = loadval_q;
    assign COUNTERREADEN  = (state_q == S_RDWAIT) && (cnt_q == 8'd0);
    assign DBG_STATE      = state_q;
    assign DBG_OVF        = ovf_q;

endmodule

// File: tb/tb_phaser_in_tap_ctrl.sv
// Directed bench for phaser_in_tap_ctrl (FINE_MAX=40, SETTLE_CYCLES=8, READ_LAT=2).
module tb_phaser_in_tap_ctrl;
  localparam int S  = 8;
  localparam int RL = 2;

  logic       SYSCLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic [1:0] REQ_OP = 2'b00;
  logic [5:0] REQ_DATA = 6'd0;
  logic       RSP_VALID;
  logic       RSP_READY = 1'b0;
  logic [5:0] RSP_DATA;
  logic       RSP_ERR;
  logic [5:0] FINE_TAP;
  logic       FINEENABLE, FINEINC, COUNTERLOADEN, COUNTERREADEN;
  logic [5:0] COUNTERLOADVAL;
  logic       FINEOVERFLOW = 1'b0;
  logic [5:0] COUNTERREADVAL;
  logic [2:0] DBG_STATE;
  logic       DBG_OVF;

  phaser_in_tap_ctrl #(.FINE_MAX(40), .SETTLE_CYCLES(S), .READ_LAT(RL)) dut (
    .SYSCLK(SYSCLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_OP(REQ_OP), .REQ_DATA(REQ_DATA), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR), .FINE_TAP(FINE_TAP), .FINEENABLE(FINEENABLE),
    .FINEINC(FINEINC), .COUNTERLOADEN(COUNTERLOADEN), .COUNTERLOADVAL(COUNTERLOADVAL),
    .COUNTERREADEN(COUNTERREADEN), .FINEOVERFLOW(FINEOVERFLOW),
    .COUNTERREADVAL(COUNTERREADVAL), .DBG_STATE(DBG_STATE), .DBG_OVF(DBG_OVF)
  );

  // clock / reset-independent PHASER_IN counter model
  always #5 SYSCLK = ~SYSCLK;

  logic [5:0] ctr_model = 6'h33;
  logic [RL-1:0] rd_sr = '0;
  always @(posedge SYSCLK) begin
    rd_sr <= {rd_sr[RL-2:0], COUNTERREADEN};
    if (COUNTERLOADEN) ctr_model <= COUNTERLOADVAL;
  end
  // Readback is only correct in the sample cycle; elsewhere it shows a corrupted value.
  assign COUNTERREADVAL = rd_sr[RL-1] ? ctr_model : ~ctr_model;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " req_ready"}, REQ_READY, 1);
    check({tag, " rsp_valid"}, RSP_VALID, 0);
    check({tag, " rsp_data"}, RSP_DATA, 0);
    check({tag, " rsp_err"}, RSP_ERR, 0);
    check({tag, " fine_tap"}, FINE_TAP, 0);
    check({tag, " pulses"}, {FINEENABLE, FINEINC, COUNTERLOADEN, COUNTERREADEN}, 0);
    check({tag, " loadval"}, COUNTERLOADVAL, 0);
    check({tag, " state"}, DBG_STATE, 0);
  endtask

  // results of the last run_req
  int         got_lat, got_fine, got_inc, got_load, got_read;
  int         got_first, got_gap_bad, got_misc_bad;
  logic [5:0] got_data;
  logic       got_err;

  task automatic run_req(input logic [1:0] op, input logic [5:0] data, input int ovf_after);
    int cyc;
    int prev;
    got_lat = -1; got_fine = 0; got_inc = 0; got_load = 0; got_read = 0;
    got_first = -1; got_gap_bad = 0; got_misc_bad = 0; prev = -1;
    @(negedge SYSCLK);
    REQ_VALID = 1'b1; REQ_OP = op; REQ_DATA = data;
    @(negedge SYSCLK);
    REQ_VALID = 1'b0;
    REQ_OP = 2'($urandom_range(0, 3));
    REQ_DATA = 6'($urandom_range(0, 63));
    cyc = 1;
    while (cyc < 2000 && !RSP_VALID) begin
      if (FINEENABLE) begin
        got_fine++;
        if (FINEINC) got_inc++;
        if (prev < 0) got_first = cyc;
        else if (cyc - prev != 1 + S) got_gap_bad++;
        prev = cyc;
        if (ovf_after > 0 && got_fine == ovf_after) FINEOVERFLOW = 1'b1;
      end else if (FINEINC) got_misc_bad++;
      if (COUNTERLOADEN) begin
        got_load++;
        if (COUNTERLOADVAL !== data || cyc != 1) got_misc_bad++;
      end
      if (COUNTERREADEN) begin
        got_read++;
        if (cyc != 1) got_misc_bad++;
      end
      @(negedge SYSCLK);
      cyc++;
    end
    if (RSP_VALID) got_lat = cyc;
    got_data = RSP_DATA;
    got_err = RSP_ERR;
  endtask

  task automatic rsp_ack(input int hold, input string tag);
    if (hold > 0) begin
      REQ_VALID = 1'b1; REQ_OP = 2'b01; REQ_DATA = 6'h3C;
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge SYSCLK);
      check({tag, " hold rsp_valid"}, RSP_VALID, 1);
      check({tag, " hold rsp_data"}, RSP_DATA, got_data);
      check({tag, " hold rsp_err"}, RSP_ERR, got_err);
      check({tag, " hold req_ready"}, REQ_READY, 0);
    end
    RSP_READY = 1'b1;
    @(negedge SYSCLK);
    RSP_READY = 1'b0;
    REQ_VALID = 1'b0;
    check({tag, " ack rsp_valid"}, RSP_VALID, 0);
    check({tag, " ack req_ready"}, REQ_READY, 1);
    check({tag, " ack no accept"}, COUNTERLOADEN, 0);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [5:0] data;
    int         hold;
    logic [5:0] exp_data;
    logic       exp_err;
    int         exp_lat;
    int         exp_fine;
    int         exp_inc;
    int         exp_load;
    int         exp_read;
    logic [5:0] exp_tap;
  } vec_t;

  vec_t vecs[15];

  initial begin
    //         op     data   hold  rdata  err   lat              fine inc load read tap
    vecs[0]  = '{2'b10, 6'h00, 0, 6'h33, 1'b0, 2 + RL,          0,  0,  0, 1, 6'd0};
    vecs[1]  = '{2'b00, 6'd5,  0, 6'd5,  1'b0, 1 + 5 * (1 + S), 5,  5,  0, 0, 6'd5};
    vecs[2]  = '{2'b11, 6'h17, 5, 6'd0,  1'b0, 1 + 5 * (1 + S), 5,  0,  0, 0, 6'd0};
    vecs[3]  = '{2'b00, 6'd0,  0, 6'd0,  1'b0, 1,               0,  0,  0, 0, 6'd0};
    vecs[4]  = '{2'b00, 6'd3,  0, 6'd3,  1'b0, 1 + 3 * (1 + S), 3,  3,  0, 0, 6'd3};
    vecs[5]  = '{2'b00, 6'd50, 2, 6'd3,  1'b1, 1,               0,  0,  0, 0, 6'd3};
    vecs[6]  = '{2'b00, 6'd41, 0, 6'd3,  1'b1, 1,               0,  0,  0, 0, 6'd3};
    vecs[7]  = '{2'b00, 6'd63, 0, 6'd3,  1'b1, 1,               0,  0,  0, 0, 6'd3};
    vecs[8]  = '{2'b01, 6'h2A, 3, 6'h2A, 1'b0, 2 + S,           0,  0,  1, 0, 6'd3};
    vecs[9]  = '{2'b10, 6'h00, 0, 6'h2A, 1'b0, 2 + RL,          0,  0,  0, 1, 6'd3};
    vecs[10] = '{2'b00, 6'd40, 0, 6'd40, 1'b0, 1 + 37 * (1 + S), 37, 37, 0, 0, 6'd40};
    vecs[11] = '{2'b00, 6'd39, 0, 6'd39, 1'b0, 1 + 1 * (1 + S), 1,  0,  0, 0, 6'd39};
    vecs[12] = '{2'b11, 6'h3F, 0, 6'd0,  1'b0, 1 + 39 * (1 + S), 39, 0, 0, 0, 6'd0};
    vecs[13] = '{2'b01, 6'h15, 0, 6'h15, 1'b0, 2 + S,           0,  0,  1, 0, 6'd0};
    vecs[14] = '{2'b10, 6'h2A, 0, 6'h15, 1'b0, 2 + RL,          0,  0,  0, 1, 6'd0};

    repeat (3) @(negedge SYSCLK);
    check_reset_vals("reset");
    RST_N = 1'b1;

    for (int i = 0; i < 15; i++) begin
      string t;
      t = $sformatf("v%0d", i);
      run_req(vecs[i].op, vecs[i].data, 0);
      check({t, " latency"}, got_lat, vecs[i].exp_lat);
      check({t, " rsp_data"}, got_data, vecs[i].exp_data);
      check({t, " rsp_err"}, got_err, vecs[i].exp_err);
      check({t, " fine pulses"}, got_fine, vecs[i].exp_fine);
      check({t, " fineinc"}, got_inc, vecs[i].exp_inc);
      check({t, " load pulses"}, got_load, vecs[i].exp_load);
      check({t, " read pulses"}, got_read, vecs[i].exp_read);
      check({t, " spacing"}, got_gap_bad, 0);
      check({t, " pulse misc"}, got_misc_bad, 0);
      if (vecs[i].exp_fine > 0) check({t, " first step"}, got_first, 1);
      rsp_ack(vecs[i].hold, t);
      check({t, " fine_tap"}, FINE_TAP, vecs[i].exp_tap);
    end

    // reset in the middle of a 5-step op
    @(negedge SYSCLK);
    REQ_VALID = 1'b1; REQ_OP = 2'b00; REQ_DATA = 6'd5;
    @(negedge SYSCLK);
    REQ_VALID = 1'b0;
    for (int k = 1; k < 20; k++) @(negedge SYSCLK);
    check("midop tap", FINE_TAP, 3);
    RST_N = 1'b0;
    @(negedge SYSCLK);
    check_reset_vals("midop reset");
    RST_N = 1'b1;
    repeat (3) @(negedge SYSCLK);
    check("post reset idle", {REQ_READY, FINEENABLE, FINE_TAP}, {1'b1, 1'b0, 6'd0});

    // FINEOVERFLOW raised after the third step of a target of 10
    run_req(2'b00, 6'd10, 3);
`ifdef PHASER_IN_TAP_CTRL_OVF_ABORT_EN
    check("ovf latency", got_lat, 1 + 3 * (1 + S));
    check("ovf rsp_data", got_data, 3);
    check("ovf rsp_err", got_err, 1);
    check("ovf pulses", got_fine, 3);
`else
    check("ovf latency", got_lat, 1 + 10 * (1 + S));
    check("ovf rsp_data", got_data, 10);
    check("ovf rsp_err", got_err, 0);
    check("ovf pulses", got_fine, 10);
`endif
    FINEOVERFLOW = 1'b0;
    rsp_ack(0, "ovf");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
